// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scanner; one digit per BLANK+DWELL slot, registered outputs, new values commit at frame wrap.
// Handshake holds value_ready low while a value waits for the wrap; DISPLAY_SCAN_PWM_EN adds brightness PWM gating.
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    input  logic                    lz_suppress,
`ifdef DISPLAY_SCAN_PWM_EN
    input  logic [3:0]              brightness,
`endif
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_full_q, pend_full_d;
    logic                    ready_q, ready_d;
    logic [3:0]              bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    frame_q, frame_d;
    logic [NUM_DIGITS-1:0]   sup;
    logic                    zero_above;
    logic                    accept;
    logic                    lit;
`ifdef DISPLAY_SCAN_PWM_EN
    logic [3:0]              pwm_q, pwm_d;
`endif

    always_comb begin
        accept      = value_valid && ready_q;
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        // Ready reopens one cycle after a commit empties the pending slot.
        ready_d     = !pend_full_q;
        frame_d     = 1'b0;

        if (accept) begin
            pend_d      = value_in;
            pend_full_d = 1'b1;
            ready_d     = 1'b0;
        end

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        idx_d   = '0;
                        frame_d = 1'b1;
                        if (pend_full_q) begin
                            disp_d      = pend_q;
                            pend_full_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase

        lit = (state_d == ST_SHOW);
`ifdef DISPLAY_SCAN_PWM_EN
        pwm_d = (state_q == ST_SHOW) ? pwm_q + 4'd1 : 4'd0;
        lit   = lit && (pwm_d <= brightness);
`endif

        // Walk from the top digit so zero_above covers this nibble and every one above it.
        bcd_d      = '0;
        en_d       = '0;
        sup        = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (disp_d[4*k +: 4] == 4'd0);
            sup[k]     = zero_above && (k != 0);
            if (idx_d == IDX_W'(k)) begin
                bcd_d   = disp_d[4*k +: 4];
                en_d[k] = lit && !(lz_suppress && sup[k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b1;
            bcd_q       <= '0;
            en_q        <= '0;
            frame_q     <= 1'b0;
`ifdef DISPLAY_SCAN_PWM_EN
            pwm_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            ready_q     <= ready_d;
            bcd_q       <= bcd_d;
            en_q        <= en_d;
            frame_q     <= frame_d;
`ifdef DISPLAY_SCAN_PWM_EN
            pwm_q       <= pwm_d;
`endif
        end
    end

    assign value_ready = ready_q;
    assign bcd         = bcd_q;
    assign digit_en    = en_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: frame-position model checked every cycle plus hand-computed spot checks.
module tb_display_scan_ctrl;
    localparam int ND    = 4;
    localparam int DW    = 8;
    localparam int BL    = 2;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_in;
    logic        value_valid;
    logic        value_ready;
    logic        lz_suppress;
    logic [3:0]  bcd;
    logic [3:0]  digit_en;
    logic        frame_start;
`ifdef DISPLAY_SCAN_PWM_EN
    logic [3:0]  brightness = 4'hF;
`endif

    display_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .lz_suppress(lz_suppress),
`ifdef DISPLAY_SCAN_PWM_EN
        .brightness (brightness),
`endif
        .bcd        (bcd),
        .digit_en   (digit_en),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: cycles since reset release, committed and pending values.
    int          t = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_full = 1'b0;
    int          m_commit_t = -1;
    bit          m_lz = 1'b0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
        end
    endfunction

    function automatic int exp_ready();
        return (!m_full && t != m_commit_t) ? 1 : 0;
    endfunction

    function automatic int exp_bcd();
        int slot = (t % FRAME) / SLOT;
        return int'((m_disp >> (4 * slot)) & 16'hF);
    endfunction

    function automatic int exp_en();
        int  p    = t % FRAME;
        int  slot = p / SLOT;
        bit  sup  = m_lz && slot > 0 && ((m_disp >> (4 * slot)) == 16'h0);
        return ((p % SLOT) >= BL && !sup) ? (1 << slot) : 0;
    endfunction

    function automatic int exp_fs();
        return (t > 0 && t % FRAME == 0) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; m_disp = '0; m_full = 1'b0; m_commit_t = -1; m_lz = 1'b0;
        end else begin
            if (value_valid && exp_ready() == 1) begin
                m_pend = value_in;
                m_full = 1'b1;
            end
            m_lz = lz_suppress;
            t = t + 1;
            if (t % FRAME == 0 && m_full) begin
                m_disp = m_pend;
                m_full = 1'b0;
                m_commit_t = t;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("digit_en", digit_en, exp_en());
            chk("bcd", bcd, exp_bcd());
            chk("frame_start", frame_start, exp_fs());
            chk("value_ready", value_ready, exp_ready());
        end
    end

    task automatic wait_t(int n);
        int budget = 0;
        while (t != n && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (t != n) begin
            total++;
            bad++;
            $display("FAIL wait_t target=%0d now=%0d", n, t);
        end
    endtask

    initial begin
        value_in = '0; value_valid = 1'b0; lz_suppress = 1'b0;
        #12;
        chk("rst_en", digit_en, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_rdy", value_ready, 1);
        @(posedge clk); #2 rst_n = 1'b1;

        wait_t(1);  #1 chk("t1_en", digit_en, 0);
        wait_t(2);  #1 chk("t2_en", digit_en, 4'b0001);
        wait_t(9);  #1 chk("t9_en", digit_en, 4'b0001);
        wait_t(10); #1 chk("t10_en", digit_en, 0);
        wait_t(12); #1 chk("t12_en", digit_en, 4'b0010);
        wait_t(15); value_in = 16'h1234; value_valid = 1'b1;
        wait_t(16); value_valid = 1'b0; #1 chk("t16_rdy", value_ready, 0);
        wait_t(39); #1 chk("t39_bcd", bcd, 0); chk("t39_fs", frame_start, 0);
        wait_t(40); #1 chk("t40_fs", frame_start, 1); chk("t40_bcd", bcd, 4);
        wait_t(41); #1 chk("t41_rdy", value_ready, 1); chk("t41_fs", frame_start, 0);
        wait_t(42); #1 chk("t42_en", digit_en, 4'b0001); chk("t42_bcd", bcd, 4);

        wait_t(45); value_in = 16'h1111; value_valid = 1'b1;
        wait_t(46); value_in = 16'h2222; #1 chk("t46_rdy", value_ready, 0);
        wait_t(52); #1 chk("t52_bcd", bcd, 3); chk("t52_en", digit_en, 4'b0010);
        wait_t(72); #1 chk("t72_bcd", bcd, 1); chk("t72_en", digit_en, 4'b1000);
        wait_t(80); #1 chk("t80_bcd", bcd, 1); chk("t80_fs", frame_start, 1); chk("t80_rdy", value_ready, 0);
        wait_t(81); #1 chk("t81_rdy", value_ready, 1);
        wait_t(82); value_valid = 1'b0; #1 chk("t82_rdy", value_ready, 0);
        wait_t(120); #1 chk("t120_fs", frame_start, 1); chk("t120_bcd", bcd, 2);
        wait_t(122); #1 chk("t122_en", digit_en, 4'b0001); chk("t122_bcd", bcd, 2);

        wait_t(125); value_in = 16'h0040; value_valid = 1'b1;
        wait_t(126); value_valid = 1'b0;
        wait_t(130); lz_suppress = 1'b1;
        wait_t(165); #1 chk("t165_en", digit_en, 4'b0001); chk("t165_bcd", bcd, 0);
        value_in = 16'h0000; value_valid = 1'b1;
        wait_t(166); value_valid = 1'b0;
        wait_t(175); #1 chk("t175_en", digit_en, 4'b0010); chk("t175_bcd", bcd, 4);
        wait_t(185); #1 chk("t185_en", digit_en, 0); chk("t185_bcd", bcd, 0);
        wait_t(195); #1 chk("t195_en", digit_en, 0);
        wait_t(205); #1 chk("t205_en", digit_en, 4'b0001);
        wait_t(215); #1 chk("t215_en", digit_en, 0);
        wait_t(230); lz_suppress = 1'b0;
        wait_t(235); #1 chk("t235_en", digit_en, 4'b1000);

        wait_t(245); value_in = 16'h5678; value_valid = 1'b1;
        wait_t(246); value_valid = 1'b0;
        wait_t(265); #1 chk("t265_en", digit_en, 4'b0100); chk("t265_rdy", value_ready, 0);
        rst_n = 1'b0;
        #1 chk("arst_en", digit_en, 0); chk("arst_rdy", value_ready, 1); chk("arst_bcd", bcd, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        wait_t(1);  #1 chk("r1_en", digit_en, 0);
        wait_t(2);  #1 chk("r2_en", digit_en, 4'b0001); chk("r2_bcd", bcd, 0);
        wait_t(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
